// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: machine timer (mtime/mtimecmp), external IRQ synchronizer and
// one-shot interrupt request FSM feeding CSR_RegisterFile.interrupt[1:0].
// Optional build macro IRQ_EDGE_EN: meip becomes a sticky rising-edge latch
// cleared by writes to EXT_CLR; otherwise meip is the synchronized level.
module irq_timer_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PRESCALE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq_i,
  input  logic        mmio_wr,
  input  logic [2:0]  mmio_addr,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  input  logic        mstatus_mie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        pipe_ok,
  input  logic        is_mret,
  output logic [1:0]  interrupt,
  output logic        mtip,
  output logic        meip
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [1:0]         irq_next;
  logic [63:0]        mtime, mtimecmp;
  logic [31:0]        psc_cnt;
  logic               tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi;
  logic               ext_ok, tmr_ok;

  assign wr_mtime_lo = mmio_wr && (mmio_addr == 3'd0);
  assign wr_mtime_hi = mmio_wr && (mmio_addr == 3'd1);
  assign wr_cmp_lo   = mmio_wr && (mmio_addr == 3'd2);
  assign wr_cmp_hi   = mmio_wr && (mmio_addr == 3'd3);
  assign tick        = (psc_cnt == 32'(PRESCALE - 1));

  // Prescale counter: tick fires on every PRESCALE-th cycle
  always_ff @(posedge clk) begin
    if (reset || tick) psc_cnt <= '0;
    else               psc_cnt <= psc_cnt + 32'd1;
  end

  // mtime: a write to either half replaces it and suppresses that cycle's increment
  always_ff @(posedge clk) begin
    if (reset)            mtime <= '0;
    else if (wr_mtime_lo) mtime[31:0]  <= mmio_wdata;
    else if (wr_mtime_hi) mtime[63:32] <= mmio_wdata;
    else if (tick)        mtime <= mtime + 64'd1;
  end

  // mtimecmp register halves
  always_ff @(posedge clk) begin
    if (reset)          mtimecmp <= '1;
    else if (wr_cmp_lo) mtimecmp[31:0]  <= mmio_wdata;
    else if (wr_cmp_hi) mtimecmp[63:32] <= mmio_wdata;
  end

  // Registered unsigned timer compare
  always_ff @(posedge clk) begin
    if (reset) mtip <= 1'b0;
    else       mtip <= (mtime >= mtimecmp);
  end

  // External pin synchronizer; sync_q[0] is the first stage
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq_i};
  end

`ifdef IRQ_EDGE_EN
  logic meip_q;
  logic ext_clr;
  assign ext_clr = mmio_wr && (mmio_addr == 3'd5);
  // Sticky pending latch: the rise is detected one stage early so it lands
  // in the same cycle the last stage goes high; set beats clear.
  always_ff @(posedge clk) begin
    if (reset)                                          meip_q <= 1'b0;
    else if (sync_q[SYNC_STAGES-2] && !sync_q[SYNC_STAGES-1]) meip_q <= 1'b1;
    else if (ext_clr)                                   meip_q <= 1'b0;
  end
  assign meip = meip_q;
`else
  assign meip = sync_q[SYNC_STAGES-1];
`endif

  assign ext_ok = meip && mie_meie;
  assign tmr_ok = mtip && mie_mtie;

  // State and registered interrupt output
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 2'b00;
    end else begin
      state     <= state_next;
      interrupt <= irq_next;
    end
  end

  // Next-state logic; source is chosen on the IDLE->FIRE transition
  always_comb begin
    state_next = state;
    irq_next   = 2'b00;
    case (state)
      IDLE: begin
        if (pipe_ok && mstatus_mie && (ext_ok || tmr_ok)) begin
          state_next = FIRE;
          irq_next   = ext_ok ? 2'b10 : 2'b01;
        end
      end
      FIRE:    state_next = ACTIVE;
      ACTIVE:  if (is_mret) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational register read mux
  always_comb begin
    mmio_rdata = '0;
    case (mmio_addr)
      3'd0:    mmio_rdata = mtime[31:0];
      3'd1:    mmio_rdata = mtime[63:32];
      3'd2:    mmio_rdata = mtimecmp[31:0];
      3'd3:    mmio_rdata = mtimecmp[63:32];
      3'd4:    mmio_rdata = {28'd0, state, meip, mtip};
      default: mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Self-checking bench for irq_timer_ctrl (default parameters).
module tb_irq_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext_irq_i;
  logic        mmio_wr;
  logic [2:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mstatus_mie, mie_mtie, mie_meie, pipe_ok, is_mret;
  logic [1:0]  interrupt;
  logic        mtip, meip;

  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_irq;

  irq_timer_ctrl #(.SYNC_STAGES(2), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .ext_irq_i(ext_irq_i),
    .mmio_wr(mmio_wr), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .mstatus_mie(mstatus_mie), .mie_mtie(mie_mtie),
    .mie_meie(mie_meie), .pipe_ok(pipe_ok), .is_mret(is_mret),
    .interrupt(interrupt), .mtip(mtip), .meip(meip)
  );

  always #5 clk = ~clk;

  // Scoreboard: every nonzero interrupt pulse must match the oldest expected request
  always @(negedge clk) begin
    if (interrupt !== 2'b00) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: interrupt=%b, expected no request", interrupt);
      end else begin
        exp_irq = exp_q.pop_front();
        if (interrupt !== exp_irq) begin
          fails++;
          $display("FAIL sb_code: interrupt=%b, expected %b", interrupt, exp_irq);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic mmio_write(input logic [2:0] a, input logic [31:0] d);
    mmio_wr = 1'b1; mmio_addr = a; mmio_wdata = d;
    @(negedge clk);
    mmio_wr = 1'b0;
  endtask

  task automatic do_mret();
    is_mret = 1'b1;
    @(negedge clk);
    is_mret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (interrupt !== 2'b00 || mtip !== 1'b0 || meip !== 1'b0) begin
      fails++; $display("FAIL rst_outs: int=%b mtip=%b meip=%b, expected 00 0 0", interrupt, mtip, meip); end
    mmio_addr = 3'd0; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL rst_mtime: got %h, expected 0", mmio_rdata); end
    mmio_addr = 3'd3; #1;
    tests++; if (mmio_rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_cmp_hi: got %h, expected ffffffff", mmio_rdata); end
    mmio_addr = 3'd4; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL rst_stat: got %h, expected 0", mmio_rdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timer_fire();
    bit seen = 0;
    mmio_write(3'd3, 32'd0);
    mmio_write(3'd0, 32'd0);
    mmio_write(3'd1, 32'd0);
    mmio_write(3'd2, 32'd10);
    mie_mtie = 1'b1; pipe_ok = 1'b1; mstatus_mie = 1'b1;
    exp_q.push_back(2'b01);
    mmio_addr = 3'd0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (mmio_rdata == 32'd10) seen = 1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL tf_timeout: mtime never read 10"); end
    tests++; if (mtip !== 1'b0) begin fails++; $display("FAIL tf_mtip_lag: mtip=%b at mtime=10, expected 0", mtip); end
    @(negedge clk); #1;
    tests++; if (mtip !== 1'b1 || mmio_rdata !== 32'd11) begin
      fails++; $display("FAIL tf_mtip_set: mtip=%b mtime=%0d, expected 1 at 11", mtip, mmio_rdata); end
    @(negedge clk); mmio_addr = 3'd4; #1;
    tests++; if (interrupt !== 2'b01 || mmio_rdata[3:2] !== 2'd1) begin
      fails++; $display("FAIL tf_fire: int=%b state=%0d, expected 01 state 1", interrupt, mmio_rdata[3:2]); end
    @(negedge clk); #1;
    tests++; if (interrupt !== 2'b00 || mmio_rdata[3:2] !== 2'd2) begin
      fails++; $display("FAIL tf_active: int=%b state=%0d, expected 00 state 2", interrupt, mmio_rdata[3:2]); end
    mstatus_mie = 1'b0;
    do_mret(); #1;
    tests++; if (mmio_rdata[3:2] !== 2'd0) begin fails++; $display("FAIL tf_mret: state=%0d, expected 0", mmio_rdata[3:2]); end
  endtask

  task automatic test_priority();
    ext_irq_i = 1'b1; mie_meie = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (meip !== 1'b1 || mtip !== 1'b1) begin
      fails++; $display("FAIL pr_pending: meip=%b mtip=%b, expected 1 1", meip, mtip); end
    mstatus_mie = 1'b1;
    exp_q.push_back(2'b10);
    @(negedge clk);
    tests++; if (interrupt !== 2'b10) begin fails++; $display("FAIL pr_ext: int=%b, expected 10", interrupt); end
    @(negedge clk);
    mie_meie = 1'b0;
    exp_q.push_back(2'b01);
    do_mret();
    @(negedge clk);
    tests++; if (interrupt !== 2'b01) begin fails++; $display("FAIL pr_tmr: int=%b, expected 01", interrupt); end
    mstatus_mie = 1'b0; ext_irq_i = 1'b0;
    @(negedge clk);
    do_mret();
  endtask

  task automatic test_gating();
    pipe_ok = 1'b0; mstatus_mie = 1'b1; mmio_addr = 3'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      tests++; if (interrupt !== 2'b00 || mmio_rdata[3:2] !== 2'd0) begin
        fails++; $display("FAIL gt_pipe: cycle %0d int=%b state=%0d, expected 00 idle", i, interrupt, mmio_rdata[3:2]); end
    end
    pipe_ok = 1'b1;
    exp_q.push_back(2'b01);
    @(negedge clk);
    tests++; if (interrupt !== 2'b01) begin fails++; $display("FAIL gt_release: int=%b, expected 01", interrupt); end
    mstatus_mie = 1'b0;
    @(negedge clk);
    do_mret();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (interrupt !== 2'b00) begin fails++; $display("FAIL gt_mie: int=%b, expected 00", interrupt); end
    end
  endtask

  task automatic test_no_nesting();
    mmio_addr = 3'd4;
    do_mret(); #1;
    tests++; if (mmio_rdata[3:2] !== 2'd0 || interrupt !== 2'b00) begin
      fails++; $display("FAIL nn_idle_mret: state=%0d int=%b, expected idle 00", mmio_rdata[3:2], interrupt); end
    mstatus_mie = 1'b1;
    exp_q.push_back(2'b01);
    @(negedge clk);
    is_mret = 1'b1;
    @(negedge clk); is_mret = 1'b0; #1;
    tests++; if (mmio_rdata[3:2] !== 2'd2) begin fails++; $display("FAIL nn_fire_mret: state=%0d, expected 2", mmio_rdata[3:2]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      tests++; if (interrupt !== 2'b00 || mmio_rdata[3:2] !== 2'd2) begin
        fails++; $display("FAIL nn_hold: int=%b state=%0d, expected 00 state 2", interrupt, mmio_rdata[3:2]); end
    end
    mstatus_mie = 1'b0;
    do_mret();
  endtask

  task automatic test_reset_mid();
    mstatus_mie = 1'b1;
    exp_q.push_back(2'b01);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mmio_addr = 3'd4; #1;
    tests++; if (mmio_rdata !== 32'd0 || interrupt !== 2'b00) begin
      fails++; $display("FAIL rm_stat: stat=%h int=%b, expected 0 00", mmio_rdata, interrupt); end
    mmio_addr = 3'd2; #1;
    tests++; if (mmio_rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rm_cmp: got %h, expected ffffffff", mmio_rdata); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    mstatus_mie = 1'b0;
  endtask

  task automatic test_timer_wrap();
    mmio_write(3'd0, 32'hFFFF_FFFF);
    mmio_write(3'd1, 32'hFFFF_FFFF);
    mmio_addr = 3'd1; #1;
    tests++; if (mmio_rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL tw_hi: got %h, expected ffffffff", mmio_rdata); end
    @(negedge clk); mmio_addr = 3'd0; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL tw_wrap_lo: got %h, expected 0", mmio_rdata); end
    mmio_addr = 3'd1; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL tw_wrap_hi: got %h, expected 0", mmio_rdata); end
    mmio_write(3'd0, 32'h0000_1234);
    mmio_addr = 3'd0; #1;
    tests++; if (mmio_rdata !== 32'h0000_1234) begin fails++; $display("FAIL tw_wins: got %h, expected 00001234", mmio_rdata); end
    @(negedge clk); #1;
    tests++; if (mmio_rdata !== 32'h0000_1235) begin fails++; $display("FAIL tw_inc: got %h, expected 00001235", mmio_rdata); end
    mmio_write(3'd2, 32'hABCD_0000);
    mmio_addr = 3'd2; #1;
    tests++; if (mmio_rdata !== 32'hABCD_0000) begin fails++; $display("FAIL tw_cmp: got %h, expected abcd0000", mmio_rdata); end
    mmio_write(3'd6, 32'h55);
    mmio_addr = 3'd6; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL tw_off6: got %h, expected 0", mmio_rdata); end
    mmio_addr = 3'd5; #1;
    tests++; if (mmio_rdata !== 32'd0) begin fails++; $display("FAIL tw_off5: got %h, expected 0", mmio_rdata); end
  endtask

  task automatic test_ext();
`ifdef IRQ_EDGE_EN
    mmio_write(3'd5, 32'd0);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ex_preclr: meip=%b, expected 0", meip); end
    ext_irq_i = 1'b1;
    @(negedge clk); ext_irq_i = 1'b0; #1;
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ex_lag: meip=%b, expected 0", meip); end
    @(negedge clk); #1;
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL ex_set: meip=%b, expected 1", meip); end
    repeat (4) @(negedge clk);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL ex_sticky: meip=%b, expected 1", meip); end
    mmio_write(3'd5, 32'd0);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ex_clr: meip=%b, expected 0", meip); end
`else
    mmio_write(3'd5, 32'd0);
    ext_irq_i = 1'b1;
    @(negedge clk); #1;
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ex_lag: meip=%b, expected 0", meip); end
    @(negedge clk); mmio_addr = 3'd4; #1;
    tests++; if (meip !== 1'b1 || mmio_rdata[1] !== 1'b1) begin
      fails++; $display("FAIL ex_rise: meip=%b stat1=%b, expected 1 1", meip, mmio_rdata[1]); end
    mmio_write(3'd5, 32'd0);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL ex_clr_ignored: meip=%b, expected 1", meip); end
    ext_irq_i = 1'b0;
    @(negedge clk);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL ex_fall_lag: meip=%b, expected 1", meip); end
    @(negedge clk);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL ex_fall: meip=%b, expected 0", meip); end
`endif
  endtask

  initial begin
    reset = 1'b1; ext_irq_i = 1'b0; mmio_wr = 1'b0; mmio_addr = 3'd0; mmio_wdata = '0;
    mstatus_mie = 1'b0; mie_mtie = 1'b0; mie_meie = 1'b0; pipe_ok = 1'b0; is_mret = 1'b0;
    test_reset();
    test_timer_fire();
    test_priority();
    test_gating();
    test_no_nesting();
    test_reset_mid();
    test_timer_wrap();
    test_ext();
    repeat (3) @(negedge clk);
    tests++; if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_drain: %0d expected requests never seen, expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
